// File: rtl/wt_pingpong_sched_if.sv
// wt_pingpong_sched_if: layer start/done, weight-DMA and compute handshakes of the ping-pong scheduler
interface wt_pingpong_sched_if #(
  parameter int GRP_W = 16,
  parameter int LEN_W = 12
);
  logic start;
  logic [GRP_W-1:0] num_grp;
  logic [LEN_W-1:0] grp_len;
  logic busy;
  logic done;
  logic dma_req;
  logic dma_ack;
  logic dma_bank;
  logic [GRP_W-1:0] dma_grp;
  logic [LEN_W-1:0] dma_len;
  logic dma_done;
  logic cmp_start;
  logic cmp_bank;
  logic [GRP_W-1:0] cmp_grp;
  logic cmp_done;
  // CSR / DMA / weight-FSM side
  modport master (
    output start, num_grp, grp_len, dma_ack, dma_done, cmp_done,
    input  busy, done, dma_req, dma_bank, dma_grp, dma_len, cmp_start, cmp_bank, cmp_grp
  );
  // scheduler side
  modport slave (
    input  start, num_grp, grp_len, dma_ack, dma_done, cmp_done,
    output busy, done, dma_req, dma_bank, dma_grp, dma_len, cmp_start, cmp_bank, cmp_grp
  );
endinterface

// File: rtl/wt_pingpong_sched.sv
// wt_pingpong_sched: ping-pong weight-bank scheduler overlapping group loads with group compute
module wt_pingpong_sched #(
  parameter int GRP_W = 16,
  parameter int LEN_W = 12
) (
  input logic clk,
  input logic rst,
  wt_pingpong_sched_if.slave sif
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q;
  logic [GRP_W-1:0] num_q, ld_grp_q, cp_grp_q;
  logic [LEN_W-1:0] len_q;
  logic [1:0] full_q, full_d;
  logic ld_bank_q, ld_out_q, cp_bank_q, cp_act_q;
  logic busy_q, done_q, dma_req_q, cmp_start_q;
  logic ld_fin, cp_fin, last, ld_ok, cp_ok;
  // completions, issue conditions from registered state, and bank occupancy after this edge
  always_comb begin
    ld_fin = ld_out_q & sif.dma_done;
    cp_fin = cp_act_q & sif.cmp_done;
    last = cp_fin & (cp_grp_q + GRP_W'(1) == num_q);
    ld_ok = !ld_out_q & !dma_req_q & (ld_grp_q < num_q) & !full_q[ld_bank_q];
    cp_ok = !cp_act_q & !cmp_start_q & full_q[cp_bank_q] & (cp_grp_q < num_q);
    full_d = (full_q | ({1'b0, ld_fin} << ld_bank_q)) & ~({1'b0, cp_fin} << cp_bank_q);
  end
  // layer FSM; load and compute sides advance independently while RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q <= '0;
      len_q <= '0;
      full_q <= '0;
      ld_grp_q <= '0;
      ld_bank_q <= 1'b0;
      ld_out_q <= 1'b0;
      cp_grp_q <= '0;
      cp_bank_q <= 1'b0;
      cp_act_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dma_req_q <= 1'b0;
      cmp_start_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cmp_start_q <= 1'b0;
      if (state_q == IDLE) begin
        if (sif.start) begin
          num_q <= sif.num_grp;
          len_q <= sif.grp_len;
          full_q <= '0;
          ld_grp_q <= '0;
          ld_bank_q <= 1'b0;
          ld_out_q <= 1'b0;
          cp_grp_q <= '0;
          cp_bank_q <= 1'b0;
          cp_act_q <= 1'b0;
          dma_req_q <= 1'b0;
          state_q <= (sif.num_grp != '0) ? RUN : IDLE;
          busy_q <= sif.num_grp != '0;
          done_q <= sif.num_grp == '0;
        end
      end else begin
        full_q <= full_d;
        if (dma_req_q & sif.dma_ack) begin
          dma_req_q <= 1'b0;
          ld_out_q <= 1'b1;
        end else if (ld_ok) begin
          dma_req_q <= 1'b1;
        end
        if (ld_fin) begin
          ld_out_q <= 1'b0;
          ld_bank_q <= ~ld_bank_q;
          ld_grp_q <= ld_grp_q + GRP_W'(1);
        end
        if (cp_fin) begin
          cp_act_q <= 1'b0;
          cp_bank_q <= ~cp_bank_q;
          cp_grp_q <= cp_grp_q + GRP_W'(1);
        end else if (cp_ok) begin
          cmp_start_q <= 1'b1;
          cp_act_q <= 1'b1;
        end
        if (last) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end
  assign sif.busy = busy_q;
  assign sif.done = done_q;
  assign sif.dma_req = dma_req_q;
  assign sif.dma_bank = ld_bank_q;
  assign sif.dma_grp = ld_grp_q;
  assign sif.dma_len = len_q;
  assign sif.cmp_start = cmp_start_q;
  assign sif.cmp_bank = cp_bank_q;
  assign sif.cmp_grp = cp_grp_q;
endmodule
